// File: rtl/instr_fetch_aligner.sv
// rtl/instr_fetch_aligner.sv - realigns word fetches into 32-bit instructions with PC
// Up to three buffered halfwords; C.ADDI/C.NOP expand to ADDI, other compressed forms are illegal.
module instr_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  output logic        instr_illegal_o
);

  logic [2:0][15:0] hw_q, hw_n;
  logic [1:0]       cnt_q, cnt_n;
  logic [31:0]      pc_q, pc_n;
  logic             skip_q, skip_n;

  logic             is32;
  logic             is_caddi;
  logic [15:0]      c;
  logic [11:0]      imm;
  logic [4:0]       rd;
  logic             pop;
  logic             fire;
  logic [1:0]       pop_n;
  logic [1:0]       cnt_pop;

  assign c        = hw_q[0];
  assign is32     = (c[1:0] == 2'b11);
  assign is_caddi = (c[15:13] == 3'b000) && (c[1:0] == 2'b01);
  assign imm      = {{6{c[12]}}, c[12], c[6:2]};
  assign rd       = c[11:7];

  assign fetch_ready_o = (cnt_q <= 2'd1) && !flush_i;
  assign instr_valid_o = !flush_i && (((cnt_q >= 2'd1) && !is32) || (cnt_q >= 2'd2));
  assign instr_pc_o    = pc_q;

  always_comb begin
    instr_o            = 32'h0;
    instr_compressed_o = 1'b0;
    instr_illegal_o    = 1'b0;
    if (instr_valid_o) begin
      if (is32) begin
        instr_o = {hw_q[1], hw_q[0]};
      end else begin
        instr_compressed_o = 1'b1;
        if (is_caddi) instr_o = {imm, rd, 3'b000, rd, 7'b0010011};
        else          instr_illegal_o = 1'b1;
      end
    end
  end

  assign pop     = instr_valid_o && instr_ready_i;
  assign fire    = fetch_valid_i && fetch_ready_o;
  assign pop_n   = pop ? (is32 ? 2'd2 : 2'd1) : 2'd0;
  assign cnt_pop = cnt_q - pop_n;

  // Pop shifts the buffer down first; an accepted fetch then lands at the new tail.
  always_comb begin
    hw_n   = hw_q >> {pop_n, 4'b0000};
    cnt_n  = cnt_pop;
    pc_n   = pc_q + {29'b0, pop_n, 1'b0};
    skip_n = skip_q;
    if (fire) begin
      if (skip_q) begin
        if (cnt_pop == 2'd0) hw_n[0] = fetch_data_i[31:16];
        else                 hw_n[1] = fetch_data_i[31:16];
        cnt_n  = cnt_pop + 2'd1;
        skip_n = 1'b0;
      end else begin
        if (cnt_pop == 2'd0) begin
          hw_n[0] = fetch_data_i[15:0];
          hw_n[1] = fetch_data_i[31:16];
        end else begin
          hw_n[1] = fetch_data_i[15:0];
          hw_n[2] = fetch_data_i[31:16];
        end
        cnt_n = cnt_pop + 2'd2;
      end
    end
    if (flush_i) begin
      hw_n   = '0;
      cnt_n  = 2'd0;
      pc_n   = flush_pc_i & ~32'h1;
      skip_n = flush_pc_i[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q   <= '0;
      cnt_q  <= 2'd0;
      pc_q   <= RESET_PC & ~32'h1;
      skip_q <= RESET_PC[1];
    end else begin
      hw_q   <= hw_n;
      cnt_q  <= cnt_n;
      pc_q   <= pc_n;
      skip_q <= skip_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// tb/tb_instr_fetch_aligner.sv - directed and randomized bench for instr_fetch_aligner
// Reference model is a halfword queue parsed instruction by instruction.
module tb_instr_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = 32'h0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i = 32'h0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic        instr_illegal_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o), .fetch_data_i(fetch_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_compressed_o(instr_compressed_o),
    .instr_illegal_o(instr_illegal_o)
  );

  // Output tuple {valid, instr, pc, compressed, illegal}
  function automatic logic [66:0] obs();
    return {instr_valid_o, instr_o, instr_pc_o, instr_compressed_o, instr_illegal_o};
  endfunction

  function automatic logic [66:0] tup(input logic v, input logic [31:0] i, input logic [31:0] p,
                                      input logic cm, input logic il);
    return {v, i, p, cm, il};
  endfunction

  function automatic logic [31:0] expand(input logic [15:0] h);
    int imm;
    int rd;
    imm = (h[12] ? 32 : 0) + int'(h[6:2]);
    if (imm >= 32) imm = imm - 64;
    rd = int'(h[11:7]);
    return ((32'(imm) & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
  endfunction

  function automatic logic [15:0] rand_hw();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0, 1:    return {3'b000, r[12:2], 2'b01};
      2:       return {r[15:2], 2'b11};
      3:       return 16'h0000;
      default: return r;
    endcase
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
    fetch_data_i = 32'h0; flush_pc_i = 32'h0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(); #1;
    vectors++; if (obs() !== tup(0, 0, 0, 0, 0)) begin miscompares++;
      $display("FAIL reset_outputs got %h exp %h", obs(), tup(0, 0, 0, 0, 0)); end
    vectors++; if (fetch_ready_o !== 1'b1) begin miscompares++;
      $display("FAIL reset_fetch_ready got %b exp 1", fetch_ready_o); end
  endtask

  task automatic test_basic();
    apply_reset();
    fetch_valid_i = 1; fetch_data_i = 32'h0050_0093; instr_ready_i = 1;
    @(negedge clk); fetch_valid_i = 0; #1;
    vectors++; if (obs() !== tup(1, 32'h0050_0093, 0, 0, 0)) begin miscompares++;
      $display("FAIL basic_addi got %h exp %h", obs(), tup(1, 32'h0050_0093, 0, 0, 0)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(0, 0, 4, 0, 0)) begin miscompares++;
      $display("FAIL basic_empty got %h exp %h", obs(), tup(0, 0, 4, 0, 0)); end
  endtask

  task automatic test_compressed_pair();
    apply_reset();
    fetch_valid_i = 1; fetch_data_i = 32'h0001_0001; instr_ready_i = 1;
    @(negedge clk); fetch_valid_i = 0; #1;
    vectors++; if (obs() !== tup(1, 32'h13, 0, 1, 0)) begin miscompares++;
      $display("FAIL cnop_pc0 got %h exp %h", obs(), tup(1, 32'h13, 0, 1, 0)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(1, 32'h13, 2, 1, 0)) begin miscompares++;
      $display("FAIL cnop_pc2 got %h exp %h", obs(), tup(1, 32'h13, 2, 1, 0)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(0, 0, 4, 0, 0)) begin miscompares++;
      $display("FAIL cnop_empty got %h exp %h", obs(), tup(0, 0, 4, 0, 0)); end
  endtask

  task automatic test_straddle();
    apply_reset();
    fetch_valid_i = 1; fetch_data_i = 32'h0093_0505; instr_ready_i = 1;
    @(negedge clk); fetch_valid_i = 0; #1;
    vectors++; if (obs() !== tup(1, 32'h0015_0513, 0, 1, 0)) begin miscompares++;
      $display("FAIL straddle_caddi got %h exp %h", obs(), tup(1, 32'h0015_0513, 0, 1, 0)); end
    @(negedge clk); fetch_valid_i = 1; fetch_data_i = 32'h0001_0050; #1;
    vectors++; if (obs() !== tup(0, 0, 2, 0, 0) || fetch_ready_o !== 1'b1) begin miscompares++;
      $display("FAIL straddle_partial got %h rdy %b exp %h rdy 1", obs(), fetch_ready_o,
               tup(0, 0, 2, 0, 0)); end
    @(negedge clk); fetch_valid_i = 0; #1;
    vectors++; if (obs() !== tup(1, 32'h0050_0093, 2, 0, 0)) begin miscompares++;
      $display("FAIL straddle_full got %h exp %h", obs(), tup(1, 32'h0050_0093, 2, 0, 0)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(1, 32'h13, 6, 1, 0)) begin miscompares++;
      $display("FAIL straddle_tail got %h exp %h", obs(), tup(1, 32'h13, 6, 1, 0)); end
  endtask

  task automatic test_neg_imm_illegal();
    apply_reset();
    fetch_valid_i = 1; fetch_data_i = 32'h0000_117D; instr_ready_i = 1;
    @(negedge clk); fetch_valid_i = 0; #1;
    vectors++; if (obs() !== tup(1, 32'hFFF1_0113, 0, 1, 0)) begin miscompares++;
      $display("FAIL neg_imm got %h exp %h", obs(), tup(1, 32'hFFF1_0113, 0, 1, 0)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(1, 0, 2, 1, 1)) begin miscompares++;
      $display("FAIL illegal_zero got %h exp %h", obs(), tup(1, 0, 2, 1, 1)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(0, 0, 4, 0, 0)) begin miscompares++;
      $display("FAIL illegal_advance got %h exp %h", obs(), tup(0, 0, 4, 0, 0)); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_valid_i = 1; fetch_data_i = 32'h0001_0001; instr_ready_i = 0;
    @(negedge clk); fetch_valid_i = 0; instr_ready_i = 1;
    @(negedge clk); fetch_valid_i = 1; fetch_data_i = 32'h0050_0093; instr_ready_i = 0; #1;
    vectors++; if (fetch_ready_o !== 1'b1) begin miscompares++;
      $display("FAIL bp_refill_ready got %b exp 1", fetch_ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); fetch_valid_i = 1; fetch_data_i = 32'hDEAD_BEEF; instr_ready_i = 0; #1;
      vectors++; if (fetch_ready_o !== 1'b0 || obs() !== tup(1, 32'h13, 2, 1, 0)) begin miscompares++;
        $display("FAIL bp_hold cycle %0d got %h rdy %b exp %h rdy 0", i, obs(), fetch_ready_o,
                 tup(1, 32'h13, 2, 1, 0)); end
    end
    @(negedge clk); fetch_valid_i = 0; instr_ready_i = 1; #1;
    vectors++; if (obs() !== tup(1, 32'h13, 2, 1, 0)) begin miscompares++;
      $display("FAIL bp_drain0 got %h exp %h", obs(), tup(1, 32'h13, 2, 1, 0)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(1, 32'h0050_0093, 4, 0, 0)) begin miscompares++;
      $display("FAIL bp_drain1 got %h exp %h", obs(), tup(1, 32'h0050_0093, 4, 0, 0)); end
    @(negedge clk); #1;
    vectors++; if (obs() !== tup(0, 0, 8, 0, 0)) begin miscompares++;
      $display("FAIL bp_drain_empty got %h exp %h", obs(), tup(0, 0, 8, 0, 0)); end
  endtask

  task automatic test_flush_and_async_reset();
    apply_reset();
    fetch_valid_i = 1; fetch_data_i = 32'h0001_0001; instr_ready_i = 0;
    @(negedge clk);
    flush_i = 1; flush_pc_i = 32'h0000_0102; fetch_valid_i = 1; instr_ready_i = 1; #1;
    vectors++; if (fetch_ready_o !== 1'b0 || obs() !== tup(0, 0, 0, 0, 0)) begin miscompares++;
      $display("FAIL flush_suppress got %h rdy %b exp %h rdy 0", obs(), fetch_ready_o,
               tup(0, 0, 0, 0, 0)); end
    @(negedge clk); flush_i = 0; fetch_valid_i = 1; fetch_data_i = 32'h0001_AAAA; #1;
    vectors++; if (fetch_ready_o !== 1'b1 || obs() !== tup(0, 0, 32'h102, 0, 0)) begin miscompares++;
      $display("FAIL flush_restart got %h rdy %b exp %h rdy 1", obs(), fetch_ready_o,
               tup(0, 0, 32'h102, 0, 0)); end
    @(negedge clk); fetch_valid_i = 0; #1;
    vectors++; if (obs() !== tup(1, 32'h13, 32'h102, 1, 0)) begin miscompares++;
      $display("FAIL flush_skip_low got %h exp %h", obs(), tup(1, 32'h13, 32'h102, 1, 0)); end
    @(negedge clk); fetch_valid_i = 1; fetch_data_i = 32'h0001_0001; instr_ready_i = 0; #1;
    vectors++; if (obs() !== tup(0, 0, 32'h104, 0, 0)) begin miscompares++;
      $display("FAIL flush_after got %h exp %h", obs(), tup(0, 0, 32'h104, 0, 0)); end
    @(negedge clk); fetch_valid_i = 0; #1;
    rst_n = 1'b0; #1;
    vectors++; if (obs() !== tup(0, 0, 0, 0, 0) || fetch_ready_o !== 1'b1) begin miscompares++;
      $display("FAIL async_reset got %h rdy %b exp %h rdy 1", obs(), fetch_ready_o,
               tup(0, 0, 0, 0, 0)); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] hq[$];
    logic [31:0] mpc;
    logic        mskip;
    logic        exp_fr, exp_v, is32;
    logic [66:0] exp_t;
    int          n;
    apply_reset();
    mpc = 32'h0; mskip = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fetch_valid_i = ($urandom_range(0, 9) < 6);
      fetch_data_i  = {rand_hw(), rand_hw()};
      instr_ready_i = ($urandom_range(0, 9) < 7);
      flush_i       = ($urandom_range(0, 49) == 0);
      flush_pc_i    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | ($urandom & 32'h3)) : $urandom;
      #1;
      is32   = (hq.size() >= 1) && (hq[0][1:0] == 2'b11);
      exp_fr = !flush_i && (hq.size() <= 1);
      exp_v  = !flush_i && (((hq.size() >= 1) && !is32) || (hq.size() >= 2));
      exp_t  = tup(0, 0, mpc, 0, 0);
      if (exp_v) begin
        if (is32) exp_t = tup(1, {hq[1], hq[0]}, mpc, 0, 0);
        else if (hq[0][1:0] == 2'b01 && hq[0][15:13] == 3'b000) exp_t = tup(1, expand(hq[0]), mpc, 1, 0);
        else exp_t = tup(1, 0, mpc, 1, 1);
      end
      vectors++; if (fetch_ready_o !== exp_fr) begin miscompares++;
        $display("FAIL rand_fetch_ready cycle %0d got %b exp %b", cyc, fetch_ready_o, exp_fr); end
      vectors++; if (obs() !== exp_t) begin miscompares++;
        $display("FAIL rand_instr cycle %0d got %h exp %h", cyc, obs(), exp_t); end
      if (flush_i) begin
        hq.delete();
        mpc = {flush_pc_i[31:1], 1'b0};
        mskip = flush_pc_i[1];
      end else begin
        if (exp_v && instr_ready_i) begin
          n = is32 ? 2 : 1;
          for (int k = 0; k < n; k++) void'(hq.pop_front());
          mpc = mpc + 32'(2 * n);
        end
        if (fetch_valid_i && exp_fr) begin
          if (!mskip) hq.push_back(fetch_data_i[15:0]);
          hq.push_back(fetch_data_i[31:16]);
          mskip = 1'b0;
        end
      end
      @(negedge clk);
    end
    fetch_valid_i = 0; flush_i = 0; instr_ready_i = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compressed_pair();
    test_straddle();
    test_neg_imm_illegal();
    test_backpressure();
    test_flush_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
